alu_mc: RTL

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module      : alu_mc
// Description : Multi-cycle ALU with valid/ready handshakes on request and
//               result. Opcodes 0..13 and 15 finish in one cycle. Opcode 14 is
//               an unsigned multiply built from iterative shift-add, taking BW
//               cycles regardless of operand values.
// Ports       : clk, rst (async, active-high)
//               in_valid/in_ready, in_a, in_b, opcode     - request side
//               out_valid/out_ready, out, flags           - result side
//               flags = {overflow, negative, zero}, registered with out
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mc #(
  parameter int BW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BW-1:0] in_a,
  input  logic [BW-1:0] in_b,
  input  logic [3:0]    opcode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] out,
  output logic [2:0]    flags
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_BUSY = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam int c_SW = $clog2(BW);   // shift-amount width
  localparam int c_CW = $clog2(BW);   // iteration counter width
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(BW - 1);
  localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
  localparam logic [BW-1:0]   c_INC_OVF  = {1'b0, {(BW-1){1'b1}}};

  logic [1:0]      r_state;
  logic [2*BW-1:0] r_acc;      // running product
  logic [2*BW-1:0] r_mcand;    // multiplicand, shifted left each iteration
  logic [BW-1:0]   r_mplier;   // multiplier, shifted right each iteration
  logic [c_CW-1:0] r_cnt;

  logic [BW-1:0]        w_res;
  logic                 w_ovf;
  logic                 w_logic;
  logic [c_SW-1:0]      w_shamt;
  logic signed [BW-1:0] w_sra;
  logic [2*BW-1:0]      w_acc_next;

  assign in_ready  = (r_state == c_IDLE);
  assign out_valid = (r_state == c_DONE);

  assign w_shamt = in_b[c_SW-1:0];
  assign w_sra   = $signed(in_a) >>> w_shamt;

  // Single-cycle datapath, evaluated directly on the request inputs so the
  // result can be loaded on the accepting edge.
  always_comb begin
    w_res   = '0;
    w_ovf   = 1'b0;
    w_logic = 1'b0;
    case (opcode)
      4'd0: begin
        w_res = in_a + in_b;
        w_ovf = (in_a[BW-1] == in_b[BW-1]) && (w_res[BW-1] != in_a[BW-1]);
      end
      4'd1: begin
        w_res = in_a - in_b;
        w_ovf = (in_a[BW-1] != in_b[BW-1]) && (w_res[BW-1] != in_a[BW-1]);
      end
      4'd2: begin
        w_logic = (in_a != '0) && (in_b != '0);
        w_res   = {{(BW-1){1'b0}}, w_logic};
      end
      4'd3: begin
        w_logic = (in_a != '0) || (in_b != '0);
        w_res   = {{(BW-1){1'b0}}, w_logic};
      end
      4'd4: begin
        w_logic = (in_a != '0) ^ (in_b != '0);
        w_res   = {{(BW-1){1'b0}}, w_logic};
      end
      4'd5: begin
        w_res = in_a + {{(BW-1){1'b0}}, 1'b1};
        w_ovf = (in_a == c_INC_OVF);
      end
      4'd6:    w_res = in_a;
      4'd7:    w_res = in_b;
      4'd8:    w_res = in_a & in_b;
      4'd9:    w_res = in_a | in_b;
      4'd10:   w_res = in_a ^ in_b;
      4'd11:   w_res = ~in_a;
      4'd12:   w_res = in_a << w_shamt;
      4'd13:   w_res = w_sra;
      default: w_res = '0;   // 14 handled by the multiplier, 15 reserved
    endcase
  end

  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= c_IDLE;
      out      <= '0;
      flags    <= 3'b000;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (in_valid) begin
            if (opcode == 4'd14) begin
              r_acc    <= '0;
              r_mcand  <= {{BW{1'b0}}, in_a};
              r_mplier <= in_b;
              r_cnt    <= '0;
              r_state  <= c_BUSY;
            end else begin
              out     <= w_res;
              flags   <= {w_ovf, w_res[BW-1], (w_res == '0)};
              r_state <= c_DONE;
            end
          end
        end
        c_BUSY: begin
          // One partial product per cycle; no early exit so latency is fixed.
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + c_CNT_ONE;
          if (r_cnt == c_CNT_LAST) begin
            out     <= w_acc_next[BW-1:0];
            flags   <= {(|w_acc_next[2*BW-1:BW]), w_acc_next[BW-1],
                        (w_acc_next[BW-1:0] == '0)};
            r_state <= c_DONE;
          end
        end
        c_DONE: begin
          if (out_ready) begin
            r_state <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
